// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and address helpers
// for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic [WORD_W-1:0] word_index(
        input logic [WORD_W-1:0] addr
    );
        return addr >> 2;
    endfunction

    // Misaligned, or beyond the last word of a DEPTH-word store.
    function automatic logic addr_error(
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth
    );
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/dmem_storage_array.sv
// dmem_storage_array: DEPTH x 32 word store with a synchronous
// write port and an asynchronous read port.
module dmem_storage_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with a
// programmable number of wait states before the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept, commit;
    logic        cur_write, cur_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_we;

    // With LATENCY=1 the commit lands on the accept edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        cur_write = wr_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    assign cur_err  = addr_error(cur_addr, DEPTH);
    assign mem_addr = AW'(word_index(cur_addr));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_write) ? '0 : mem_rdata;
        end
    end

    assign mem_we = commit && cur_write && !cur_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    dmem_storage_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_addr),
        .wdata (cur_wdata),
        .raddr (mem_addr),
        .rdata (mem_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of the responder
// against a word-array reference model, at LATENCY=3 and LATENCY=1.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int L     = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    logic        q_valid, q_write, q_rready;
    logic [31:0] q_addr, q_wdata;
    logic        q_ready, q_rvalid, q_error;
    logic [31:0] q_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m  [DEPTH];
    bit          wrote  [DEPTH];
    logic [31:0] mem1_m [DEPTH];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (q_valid),
        .req_ready  (q_ready),
        .req_write  (q_write),
        .req_addr   (q_addr),
        .req_wdata  (q_wdata),
        .resp_valid (q_rvalid),
        .resp_ready (q_rready),
        .resp_rdata (q_rdata),
        .resp_error (q_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, req_ready, 1);
        chk({tag, "_vld"}, resp_valid, 0);
        chk({tag, "_rd"}, resp_rdata, 0);
        chk({tag, "_err"}, resp_error, 0);
    endtask

    // Called at a negedge with the responder idle; returns at a negedge idle.
    task automatic txn(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        int idx;
        bit e;
        logic [31:0] d;
        e   = m_err(addr);
        idx = int'(addr / 4) % DEPTH;
        d   = (e || wr) ? 32'h0 : mem_m[idx];
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        @(posedge clock);
        for (int n = 1; n <= L; n++) begin
            @(negedge clock);
            if (n == 1) begin
                req_valid = 1'b0;
                req_write = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            chk("valid_timing", resp_valid, 32'(n == L));
            if (n < L) chk("wait_rdy", req_ready, 0);
        end
        chk("rdata", resp_rdata, d);
        chk("error", resp_error, 32'(e));
        chk("resp_rdy", req_ready, 0);
        if (wr && !e) begin
            mem_m[idx] = wdata;
            wrote[idx] = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_addr  = $urandom & 32'h3FC;
            @(negedge clock);
            chk("hold_vld", resp_valid, 1);
            chk("hold_rd", resp_rdata, d);
            chk("hold_err", resp_error, 32'(e));
            chk("hold_rdy", req_ready, 0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        chk("done_vld", resp_valid, 0);
        chk("done_rdy", req_ready, 1);
        chk("done_rd", resp_rdata, 0);
        chk("done_err", resp_error, 0);
    endtask

    task automatic txn1(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int idx;
        bit e;
        logic [31:0] d;
        e   = m_err(addr);
        idx = int'(addr / 4) % DEPTH;
        d   = (e || wr) ? 32'h0 : mem1_m[idx];
        q_valid  = 1'b1;
        q_write  = wr;
        q_addr   = addr;
        q_wdata  = wdata;
        q_rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        q_valid = 1'b0;
        q_addr  = $urandom;
        chk("l1_vld", q_rvalid, 1);
        chk("l1_rd", q_rdata, d);
        chk("l1_err", q_error, 32'(e));
        chk("l1_rdy", q_ready, 0);
        if (wr && !e) mem1_m[idx] = wdata;
        @(negedge clock);
        chk("l1_done_vld", q_rvalid, 0);
        chk("l1_done_rdy", q_ready, 1);
    endtask

    initial begin
        logic [31:0] a;
        int          k, idx;
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 1;
        q_valid = 0; q_write = 0; q_addr = 0; q_wdata = 0; q_rready = 1;
        #1;
        chk_reset_vals("por");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        txn(1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 32'h10, 32'h0, 0);
        txn(0, 32'h10, 32'h0, 5);

        txn(1, 32'h20, 32'h0BADF00D, 0);
        txn(1, 32'h22, 32'h12345678, 1);
        txn(0, 32'h20, 32'h0, 0);

        txn(0, 32'h400, 32'h0, 0);
        txn(1, 32'h3FC, 32'h13572468, 0);
        txn(0, 32'h3FC, 32'h0, 2);

        reset = 1'b1;
        #1;
        chk_reset_vals("idle_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        txn(1, 32'h8, 32'h11111111, 0);
        req_valid = 1; req_write = 1;
        req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
        @(posedge clock);
        @(negedge clock);
        req_valid = 0;
        reset = 1'b1;
        #1;
        chk_reset_vals("wait_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        txn(0, 32'h8, 32'h0, 0);

        req_valid = 1; req_write = 0; req_addr = 32'h10;
        resp_ready = 0;
        @(posedge clock);
        for (int n = 1; n <= L; n++) begin
            @(negedge clock);
            req_valid = 0;
        end
        chk("pre_rst_vld", resp_valid, 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("resp_rst");
        @(negedge clock);
        reset = 1'b0;
        resp_ready = 1;
        @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7) begin
                a   = 32'($urandom_range(0, 15)) * 4 + 32'h100;
                idx = int'(a / 4);
                if (k < 3 || !wrote[idx]) txn(1, a, $urandom, $urandom_range(0, 2));
                else txn(0, a, $urandom, $urandom_range(0, 2));
            end else if (k < 9) begin
                a = ($urandom & 32'h3FC) | 32'($urandom_range(1, 3));
                txn(1'($urandom), a, $urandom, 0);
            end else begin
                txn(1'($urandom), $urandom | 32'h400, $urandom, 1);
            end
        end

        txn1(1, 32'h40, 32'hA5A5A5A5);
        txn1(0, 32'h40, 32'h0);
        txn1(1, 32'h41, 32'hFFFFFFFF);
        txn1(0, 32'h40, 32'h0);
        txn1(0, 32'h400, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
